sprite_line_scheduler: RTL and testbench
========================================

Name: sprite_line_scheduler

Overview:
Builds each scanline's sprite overlay into the ping-pong line RAM ahead of the beam. It holds a CPU-written table of movable sprites. On each line_start it clears the selected line-RAM bank, then scans the table for sprites covering the target row. It then sequences sprite-ROM fetches and writes the non-transparent pixels into line RAM. It sits between the CPU I/O decode, the sprite ROM and the line-RAM write port, and is the sole write master of the line RAM.

Parameters:
NUM_SPRITES, 8, number of sprite table entries (power of 2)
IDX_W, 3, log2(NUM_SPRITES)
MAX_PER_LINE, 4, maximum sprites drawn per line

Ports:
i_Clk  in  1  system clock
i_Rst_n  in  1  asynchronous active-low reset
line_start  in  1  single-cycle pulse: build line tgt_row into bank
tgt_row  in  10  target beam row
bank  in  1  line-RAM bank to build (lb_addr[8])
cfg_we  in  1  table write strobe
cfg_addr  in  IDX_W+2  {sprite index, field[1:0]}
cfg_wdata  in  12  table write data
rom_sprite  out  6  sprite ROM sprite number
rom_row  out  3  sprite ROM row
rom_col  out  3  sprite ROM column
rom_pixel  in  2  sprite ROM data, valid 1 cycle after address
lb_we  out  1  line-RAM write enable
lb_addr  out  11  line-RAM write address {2'b00, bank, x[7:0]}
lb_wdata  out  2  line-RAM write data
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse on line completion
overflow  out  1  sticky until next line_start: more than MAX_PER_LINE hits found
overrun  out  1  one-cycle pulse: line_start arrived while busy

Behaviour:
- Reset (async, i_Rst_n=0):
  - State IDLE.
  - All table entries zero: disabled, x=0, y=0, num=0.
  - Hit list empty.
  - All outputs 0.
- Table fields (written on cfg_we, effective the next cycle; accepted in any state):
  - field 0: x = cfg_wdata[9:0]
  - field 1: y = cfg_wdata[9:0]
  - field 2: enable = cfg_wdata[6], num = cfg_wdata[5:0]
  - field 3: ignored
- Hit test per entry:
  - dy = (tgt_row − y) mod 1024.
  - Hit iff enable && dy < 16.
  - Sprite row = dy[3:1] (8x8 art, 2x scaled).
  - y near 1023 therefore hits rows 0..14 via wrap.
- States:
  - IDLE: on line_start, latch tgt_row and bank, clear overflow, go to CLEAR.
  - CLEAR: 256 cycles. lb_we=1, lb_wdata=0, lb_addr x = 0..255 ascending. Then go to SCAN.
  - SCAN: NUM_SPRITES cycles, entry i examined in cycle i (0 upward).
    - A hit appends {num, row, x[8:1]} to the hit list while count < MAX_PER_LINE.
    - Further hits set overflow and are dropped.
    - The snapshot is taken at scan time. A cfg write to the entry being scanned in the same cycle is not seen (old value used).
    - Then go to DRAW, or to DONE if the list is empty.
  - DRAW: hit list processed from the last entry to the first, so the lowest table index ends on top. Each sprite takes 9 cycles:
    - Cycles 0..7 issue rom_col = 0..7, with rom_sprite and rom_row from the entry.
    - Cycles 1..8 write column c−1 at x = (x8 + c−1) mod 256.
    - lb_we=1 only if rom_pixel != 0 (transparent pixels are not written).
  - DONE: 1 cycle with done=1, then IDLE.
- Latency: line_start at cycle 0 gives done at cycle 265 + 9·k, where k = sprites drawn (NUM_SPRITES=8). Worst case 301, below the 800-cycle line.
- line_start while busy: ignored, overrun=1 that cycle, current line continues undisturbed.
- Outputs rom_* are 0 outside DRAW. lb_* are 0 outside CLEAR/DRAW.
- Reset asserted mid-line: immediate return to IDLE, and the table is cleared.

Test Plan:
- No sprites enabled, line_start with tgt_row=100, bank=1 → 256 writes of 0 to addr 0x100..0x1FF, done exactly at cycle 265, no other lb_we.
- Entry 0: x=40, y=96, num=5, enabled; tgt_row=100 → rom_sprite=5, rom_row=2, cols 0..7 issued; nonzero pixels written at x 20..27; done at cycle 274.
- Entries 0 and 1 both at x=40, y=96, with distinct ROM patterns → entry 1 drawn first, then entry 0. Final line RAM shows entry 0 wherever its pixel != 0, and entry 1 elsewhere.
- Six enabled sprites all hitting row 50 → entries 0..3 drawn, overflow=1, done at cycle 301. Next line_start clears overflow.
- y=1020, tgt_row=3 → hit with dy=7, row 3. x=500 (x8=250) → writes wrap to x 250..255 and 0..1.
- line_start pulsed at cycle 10 of a build → overrun pulse, done timing unchanged. Reset asserted at cycle 100 → busy=0 and lb_we=0 immediately, and the table reads as disabled afterwards.

Source files
------------

// File: rtl/sprite_line_scheduler.sv
// Sprite line scheduler: clears one line-RAM bank, scans the sprite table for
// entries that cover the target row, then fetches each hit's 8 columns from
// the sprite ROM and writes the opaque pixels into the bank. The scheduler is
// the only writer of the line RAM.
module sprite_line_scheduler #(
  parameter int NUM_SPRITES  = 8,
  parameter int IDX_W        = 3,
  parameter int MAX_PER_LINE = 4
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic             line_start,
  input  logic [9:0]       tgt_row,
  input  logic             bank,
  input  logic             cfg_we,
  input  logic [IDX_W+1:0] cfg_addr,
  input  logic [11:0]      cfg_wdata,
  output logic [5:0]       rom_sprite,
  output logic [2:0]       rom_row,
  output logic [2:0]       rom_col,
  input  logic [1:0]       rom_pixel,
  output logic             lb_we,
  output logic [10:0]      lb_addr,
  output logic [1:0]       lb_wdata,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic             overrun
);

  localparam int HL_W  = (MAX_PER_LINE > 1) ? $clog2(MAX_PER_LINE) : 1;
  localparam int CNT_W = $clog2(MAX_PER_LINE + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SCAN,
    S_DRAW,
    S_DONE
  } state_t;

  state_t state, state_d;

  // Sprite table. Only x[8:1] is ever used (2x horizontal scale onto a
  // 256-pixel line), so only those bits of x are stored.
  logic [7:0] tbl_x8  [NUM_SPRITES];
  logic [9:0] tbl_y   [NUM_SPRITES];
  logic [5:0] tbl_num [NUM_SPRITES];
  logic       tbl_en  [NUM_SPRITES];

  // Hit list built during SCAN and consumed back-to-front during DRAW.
  logic [5:0] hl_num [MAX_PER_LINE];
  logic [2:0] hl_row [MAX_PER_LINE];
  logic [7:0] hl_x   [MAX_PER_LINE];
  logic [CNT_W-1:0] hl_cnt;
  logic [HL_W-1:0]  draw_idx;

  logic [7:0] cnt;
  logic [9:0] row_q;
  logic       bank_q;
  logic       overflow_q;

  logic [IDX_W-1:0] scan_idx;
  logic [IDX_W-1:0] cfg_idx;
  logic [1:0]       cfg_field;
  logic [9:0]       dy;
  logic             hit;
  logic             take;
  logic             scan_last;
  logic [CNT_W-1:0] cnt_after;
  logic [7:0]       draw_x;
  logic             unused_bits;

  assign cfg_idx   = cfg_addr[IDX_W+1:2];
  assign cfg_field = cfg_addr[1:0];

  // Hit test for the entry under scan; dy wraps mod 1024 so sprites near the
  // bottom of the frame also cover the first rows.
  assign scan_idx  = cnt[IDX_W-1:0];
  assign dy        = row_q - tbl_y[scan_idx];
  assign hit       = tbl_en[scan_idx] && (dy[9:4] == 6'd0);
  assign take      = hit && (hl_cnt < CNT_W'(MAX_PER_LINE));
  assign cnt_after = hl_cnt + CNT_W'(take);
  assign scan_last = (cnt == 8'(NUM_SPRITES - 1));
  assign draw_x    = hl_x[draw_idx] + (cnt - 8'd1);
  assign overflow  = overflow_q;

  assign unused_bits = ^{cfg_wdata[11:10], dy[0]};

  // State register.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) state <= S_IDLE;
    else          state <= state_d;
  end

  // Next-state and output decode.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_d    = state;
    busy       = (state != S_IDLE);
    done       = 1'b0;
    overrun    = line_start && (state != S_IDLE);
    lb_we      = 1'b0;
    lb_addr    = '0;
    lb_wdata   = '0;
    rom_sprite = '0;
    rom_row    = '0;
    rom_col    = '0;
    unique case (state)
      S_IDLE: begin
        if (line_start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        lb_we   = 1'b1;
        lb_addr = {2'b00, bank_q, cnt};
        if (cnt == 8'd255) state_d = S_SCAN;
      end
      S_SCAN: begin
        if (scan_last) state_d = (cnt_after == '0) ? S_DONE : S_DRAW;
      end
      S_DRAW: begin
        rom_sprite = hl_num[draw_idx];
        rom_row    = hl_row[draw_idx];
        if (cnt != 8'd8) rom_col = cnt[2:0];
        // Pixel for column cnt-1 returns from the ROM this cycle.
        if (cnt != 8'd0) begin
          lb_we    = (rom_pixel != 2'b00);
          lb_addr  = {2'b00, bank_q, draw_x};
          lb_wdata = rom_pixel;
        end
        if (cnt == 8'd8 && draw_idx == '0) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sprite table: CPU writes land the cycle after cfg_we in any state.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        tbl_x8[i]  <= '0;
        tbl_y[i]   <= '0;
        tbl_num[i] <= '0;
        tbl_en[i]  <= 1'b0;
      end
    end else if (cfg_we) begin
      // NOTE: sequential state uses non-blocking assignments so every reader
      // in this cycle (including the scan) sees the pre-write value.
      unique case (cfg_field)
        2'd0: tbl_x8[cfg_idx] <= cfg_wdata[8:1];
        2'd1: tbl_y[cfg_idx]  <= cfg_wdata[9:0];
        2'd2: begin
          tbl_en[cfg_idx]  <= cfg_wdata[6];
          tbl_num[cfg_idx] <= cfg_wdata[5:0];
        end
        default: ;
      endcase
    end
  end

  // Sequencing counter, line latches, overflow flag and hit-list pointers.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      cnt        <= '0;
      row_q      <= '0;
      bank_q     <= 1'b0;
      overflow_q <= 1'b0;
      hl_cnt     <= '0;
      draw_idx   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          cnt <= '0;
          if (line_start) begin
            row_q      <= tgt_row;
            bank_q     <= bank;
            overflow_q <= 1'b0;
            hl_cnt     <= '0;
          end
        end
        S_CLEAR: cnt <= cnt + 8'd1;
        S_SCAN: begin
          cnt <= scan_last ? 8'd0 : cnt + 8'd1;
          if (take)         hl_cnt     <= hl_cnt + CNT_W'(1);
          if (hit && !take) overflow_q <= 1'b1;
          // Drawing starts from the last hit so entry 0 is painted on top.
          if (scan_last)    draw_idx   <= HL_W'(cnt_after - CNT_W'(1));
        end
        S_DRAW: begin
          if (cnt == 8'd8) begin
            cnt <= '0;
            if (draw_idx != '0) draw_idx <= draw_idx - HL_W'(1);
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  // Hit-list payload.
  always_ff @(posedge i_Clk) begin
    // NOTE: the payload is not reset; hl_cnt alone decides which slots are
    // valid, and it is reset.
    if (state == S_SCAN && take) begin
      hl_num[hl_cnt[HL_W-1:0]] <= tbl_num[scan_idx];
      hl_row[hl_cnt[HL_W-1:0]] <= dy[3:1];
      hl_x[hl_cnt[HL_W-1:0]]   <= tbl_x8[scan_idx];
    end
  end

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Testbench for sprite_line_scheduler: a behavioural model predicts every
// line-RAM write and the done pulse of each line into a scoreboard queue; a
// monitor pops and compares whenever the DUT writes or signals done.
module tb_sprite_line_scheduler;

  localparam int NS   = 8;
  localparam int IW   = 3;
  localparam int MAXL = 4;

  logic          i_Clk = 1'b0;
  logic          i_Rst_n = 1'b0;
  logic          line_start = 1'b0;
  logic [9:0]    tgt_row = '0;
  logic          bank = 1'b0;
  logic          cfg_we = 1'b0;
  logic [IW+1:0] cfg_addr = '0;
  logic [11:0]   cfg_wdata = '0;
  logic [5:0]    rom_sprite;
  logic [2:0]    rom_row;
  logic [2:0]    rom_col;
  logic [1:0]    rom_pixel = '0;
  logic          lb_we;
  logic [10:0]   lb_addr;
  logic [1:0]    lb_wdata;
  logic          busy, done, overflow, overrun;

  sprite_line_scheduler #(.NUM_SPRITES(NS), .IDX_W(IW), .MAX_PER_LINE(MAXL)) dut (
    .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .line_start(line_start), .tgt_row(tgt_row),
    .bank(bank), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .rom_sprite(rom_sprite), .rom_row(rom_row), .rom_col(rom_col), .rom_pixel(rom_pixel),
    .lb_we(lb_we), .lb_addr(lb_addr), .lb_wdata(lb_wdata), .busy(busy), .done(done),
    .overflow(overflow), .overrun(overrun)
  );

  always #5 i_Clk = ~i_Clk;

  int cyc = 0;
  always @(posedge i_Clk) cyc++;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Sprite ROM contents: a deterministic pattern, reseeded per line.
  int rom_seed = 0;
  function automatic logic [1:0] rom_fn(input int s, input int r, input int c);
    return 2'((s * 5 + r * 11 + c * 7 + rom_seed) % 4);
  endfunction

  // ROM with one cycle of read latency.
  logic [1:0] rom_next = '0;
  always @(negedge i_Clk) rom_next = rom_fn(int'(rom_sprite), int'(rom_row), int'(rom_col));
  always begin
    @(posedge i_Clk);
    #1;
    rom_pixel = rom_next;
  end

  // Scoreboard of expected writes and done pulses, in cycle order.
  typedef struct {
    int         cyc;
    bit         is_done;
    logic [10:0] addr;
    logic [1:0]  data;
  } exp_t;
  exp_t sb[$];

  logic [1:0] lram [512];
  int done_seen = 0;

  // Monitor: every write or done is matched against the scoreboard head.
  always @(negedge i_Clk) begin
    exp_t e;
    if (i_Rst_n && (lb_we || done)) begin
      if (sb.size() == 0) begin
        check("unexpected_output", {30'd0, lb_we, done}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("out_kind", {31'd0, done}, {31'd0, e.is_done});
        check("out_cycle", cyc, e.cyc);
        if (!e.is_done) begin
          check("wr_addr", {21'd0, lb_addr}, {21'd0, e.addr});
          check("wr_data", {30'd0, lb_wdata}, {30'd0, e.data});
        end
      end
      if (lb_we) lram[lb_addr[8:0]] = lb_wdata;
      if (done) done_seen++;
    end
  end

  // Reference copy of the sprite table.
  int m_x[NS], m_y[NS], m_num[NS];
  bit m_en[NS];

  task automatic cfg_write(input int idx, input int field, input int data);
    @(negedge i_Clk);
    cfg_we    = 1'b1;
    cfg_addr  = (IW+2)'(idx * 4 + field);
    cfg_wdata = 12'(data);
    @(negedge i_Clk);
    cfg_we = 1'b0;
    case (field)
      0: m_x[idx] = data & 1023;
      1: m_y[idx] = data & 1023;
      2: begin
        m_en[idx]  = ((data >> 6) & 1) == 1;
        m_num[idx] = data & 63;
      end
      default: ;
    endcase
  endtask

  task automatic set_sprite(input int idx, input int x, input int y, input int num, input bit en);
    cfg_write(idx, 0, x);
    cfg_write(idx, 1, y);
    cfg_write(idx, 2, int'($urandom & 32'hF80) | (en ? 64 : 0) | num);
  endtask

  task automatic disable_all();
    for (int i = 0; i < NS; i++) cfg_write(i, 2, 0);
  endtask

  // Build one line and check it. ovr_at/rst_at: cycle offset for a second
  // line_start or a reset (-1 = none).
  task automatic run_line(input int tgt, input int bnk, input int ovr_at, input int rst_at);
    int hx[$], hn[$], hr[$];
    int nh, k, t0, done0, mism, dy;
    bit aborted;
    logic b;
    logic [1:0] expram [256];
    logic [1:0] p;
    nh = 0;
    aborted = 0;
    b = bnk[0];
    for (int i = 0; i < NS; i++) begin
      dy = (tgt - m_y[i] + 1024) % 1024;
      if (m_en[i] && dy < 16) begin
        nh++;
        if (hn.size() < MAXL) begin
          hn.push_back(m_num[i]);
          hr.push_back(dy / 2);
          hx.push_back((m_x[i] / 2) % 256);
        end
      end
    end
    k = hn.size();
    for (int x = 0; x < 256; x++) expram[x] = 2'd0;

    @(negedge i_Clk);
    #2;
    line_start = 1'b1;
    tgt_row    = 10'(tgt);
    bank       = b;
    t0         = cyc;
    done0      = done_seen;
    #1;
    check("overrun_idle", {31'd0, overrun}, 32'd0);
    for (int i = 0; i < 256; i++)
      sb.push_back('{cyc: t0 + 1 + i, is_done: 1'b0, addr: {2'b00, b, 8'(i)}, data: 2'd0});
    for (int j = 0; j < k; j++) begin
      int idx, base;
      idx  = k - 1 - j;
      base = t0 + 265 + 9 * j;
      for (int c = 0; c < 8; c++) begin
        p = rom_fn(hn[idx], hr[idx], c);
        if (p != 2'd0) begin
          sb.push_back('{cyc: base + 1 + c, is_done: 1'b0,
                         addr: {2'b00, b, 8'((hx[idx] + c) % 256)}, data: p});
          expram[(hx[idx] + c) % 256] = p;
        end
      end
    end
    sb.push_back('{cyc: t0 + 265 + 9 * k, is_done: 1'b1, addr: 11'd0, data: 2'd0});

    @(negedge i_Clk);
    #2;
    line_start = 1'b0;
    check("overflow_cleared", {31'd0, overflow}, 32'd0);

    for (int n = 0; n < 400; n++) begin
      if (done_seen != done0) break;
      if (cyc == t0 + ovr_at) begin
        line_start = 1'b1;
        #1;
        check("overrun_pulse", {31'd0, overrun}, 32'd1);
      end
      if (cyc == t0 + rst_at) begin
        i_Rst_n = 1'b0;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_lb_we", {31'd0, lb_we}, 32'd0);
        sb.delete();
        for (int i = 0; i < NS; i++) begin
          m_en[i] = 0; m_x[i] = 0; m_y[i] = 0; m_num[i] = 0;
        end
        aborted = 1;
        break;
      end
      @(negedge i_Clk);
      #2;
      line_start = 1'b0;
    end

    if (aborted) begin
      @(negedge i_Clk);
      i_Rst_n = 1'b1;
    end else if (done_seen == done0) begin
      check("done_timeout", 32'd0, 32'd1);
      sb.delete();
    end else begin
      check("sb_drained", sb.size(), 32'd0);
      check("overflow_flag", {31'd0, overflow}, (nh > MAXL) ? 32'd1 : 32'd0);
      @(negedge i_Clk);
      #2;
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("idle_outputs", {19'd0, lb_we, done, rom_sprite, rom_col}, 32'd0);
      mism = 0;
      for (int x = 0; x < 256; x++)
        if (lram[b * 256 + x] !== expram[x]) mism++;
      check("line_ram_mismatches", mism, 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NS; i++) begin
      m_en[i] = 0; m_x[i] = 0; m_y[i] = 0; m_num[i] = 0;
    end
    repeat (3) @(negedge i_Clk);
    check("reset_outputs", {13'd0, busy, done, overflow, overrun, lb_we, lb_wdata,
                            rom_sprite, rom_row, rom_col}, 32'd0);
    check("reset_addr", {21'd0, lb_addr}, 32'd0);
    i_Rst_n = 1'b1;
    repeat (2) @(negedge i_Clk);

    // Empty table: clear only, done at cycle 265.
    run_line(100, 1, -1, -1);

    // One sprite: x=40 (x8=20), y=96, num=5, row 2.
    rom_seed = 1;
    set_sprite(0, 40, 96, 5, 1'b1);
    run_line(100, 0, -1, -1);

    // Two overlapping sprites: entry 0 must end on top.
    rom_seed = 2;
    set_sprite(0, 40, 96, 1, 1'b1);
    set_sprite(1, 40, 96, 2, 1'b1);
    run_line(100, 1, -1, -1);

    // Six hits on row 50: four drawn, overflow, done at 301.
    disable_all();
    rom_seed = 3;
    for (int i = 0; i < 6; i++) set_sprite(i, 30 * i, 45 + i, 10 + i, 1'b1);
    run_line(50, 0, -1, -1);
    // Next line clears overflow.
    disable_all();
    run_line(50, 1, -1, -1);

    // Vertical and horizontal wrap: y=1020, row 3 -> dy=7; x=500 -> x8=250.
    rom_seed = 0;
    set_sprite(2, 500, 1020, 7, 1'b1);
    run_line(3, 0, -1, -1);

    // line_start while busy: overrun pulse, timing unchanged.
    run_line(3, 1, 10, -1);

    // Reset mid-line, then the table must behave as empty.
    set_sprite(3, 100, 200, 9, 1'b1);
    run_line(205, 0, -1, 100);
    run_line(205, 0, -1, -1);
    run_line(3, 1, -1, -1);

    // Randomized tables and rows.
    for (int t = 0; t < 15; t++) begin
      int tgt, nw;
      tgt      = int'($urandom_range(0, 1023));
      rom_seed = int'($urandom_range(0, 3));
      nw       = int'($urandom_range(1, 8));
      for (int w = 0; w < nw; w++) begin
        int idx, y;
        idx = int'($urandom_range(0, NS - 1));
        if ($urandom_range(0, 3) != 0) y = (tgt + 1024 - int'($urandom_range(0, 19))) % 1024;
        else                           y = int'($urandom_range(0, 1023));
        set_sprite(idx, int'($urandom_range(0, 1023)), y, int'($urandom_range(0, 63)),
                   $urandom_range(0, 3) != 0);
        if ($urandom_range(0, 3) == 0) cfg_write(idx, 3, int'($urandom_range(0, 4095)));
      end
      run_line(tgt, int'($urandom_range(0, 1)), -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
